dft4_sequencer: RTL
===================

DFT4_SEQUENCER -- requirements
Module: dft4_sequencer

Interface
REQ-001 SHALL have parameter WORD_SZ, default 16, sample/result word width in bits.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_s_data  input  WORD_SZ  serial input sample.
REQ-005 SHALL have port i_s_valid  input  1  input sample valid.
REQ-006 SHALL have port o_s_ready  output  1  block accepts input sample.
REQ-007 SHALL have ports o_net_A, o_net_B, o_net_C, o_net_D  output  WORD_SZ each  operands driven to the 4-point DFT network inputs.
REQ-008 SHALL have ports i_net_A, i_net_B, i_net_C, i_net_D  input  WORD_SZ each  combinational results returned from the DFT network.
REQ-009 SHALL have port o_m_data  output  WORD_SZ  serial output result.
REQ-010 SHALL have port o_m_valid  output  1  output result valid.
REQ-011 SHALL have port i_m_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_m_last  output  1  marks 4th result of a frame.
REQ-013 SHALL have port o_frame_cnt  output  8  count of completed output frames.

Function
REQ-014 SHALL implement FSM states LOAD, COMPUTE, UNLOAD.
REQ-015 Handshake: transfer occurs only in a cycle where valid and ready are both 1.
REQ-016 LOAD: o_s_ready=1, o_m_valid=0; each input transfer writes i_s_data to operand slot load_idx (0->A, 1->B, 2->C, 3->D), then load_idx increments.
REQ-017 LOAD: on transfer with load_idx=3, SHALL go to COMPUTE and clear load_idx to 0.
REQ-018 o_net_A..D SHALL be driven directly from operand registers A..D at all times.
REQ-019 COMPUTE: exactly one cycle; o_s_ready=0, o_m_valid=0; SHALL capture i_net_A..D into result registers R0..R3 and go to UNLOAD.
REQ-020 UNLOAD: o_s_ready=0, o_m_valid=1, o_m_data=R[out_idx], with out_idx 0..3 mapping to R0..R3; o_m_last=1 only when out_idx=3.
REQ-021 UNLOAD: on output transfer, out_idx increments; on transfer with out_idx=3, SHALL clear out_idx, increment o_frame_cnt, and go to LOAD.
REQ-022 While o_m_valid=1 and i_m_ready=0, o_m_data and o_m_last SHALL hold stable.
REQ-023 Latency: 4th input transfer in cycle N gives COMPUTE in N+1; first o_m_valid=1 in N+2.
REQ-024 Throughput: no LOAD/UNLOAD overlap; inputs presented outside LOAD are not accepted and SHALL NOT alter operand registers.
REQ-025 o_frame_cnt SHALL wrap 255 -> 0 with no flag.
REQ-026 Operand registers SHALL retain last-frame values after COMPUTE until overwritten by the next frame's loads.
REQ-027 i_net_* SHALL be sampled only in COMPUTE.

Reset
REQ-028 While i_rst=1: state=LOAD, load_idx=0, out_idx=0, operands=0, R0..R3=0, o_frame_cnt=0, o_s_ready=0, o_m_valid=0, o_m_last=0, o_m_data=0.
REQ-029 On first clock edge after i_rst deasserts, o_s_ready SHALL be 1.
REQ-030 Reset asserted mid-frame (any state) SHALL discard the partial frame immediately, with no output transfer completing afterwards.

Verification (bench stub: i_net_A=o_net_A+o_net_B, i_net_B=o_net_A-o_net_B, i_net_C=o_net_C+o_net_D, i_net_D=o_net_C-o_net_D)
REQ-031 Feed 1,2,3,4 back-to-back with i_m_ready=1 -> outputs 3, 0xFFFF, 7, 0xFFFF in consecutive cycles; o_m_last on the 4th only; first o_m_valid 2 cycles after 4th input; o_frame_cnt=1.
REQ-032 Same frame, i_m_ready=0 for 5 cycles at out_idx=1 -> o_m_data held at 0xFFFF and o_m_valid held at 1 throughout; sequence completes unchanged.
REQ-033 i_s_valid toggled 1,0,1,0... with data 5,6,7,8 -> operands A..D=5,6,7,8; o_net_A..D match; i_s_valid high during COMPUTE/UNLOAD is ignored (o_s_ready=0).
REQ-034 Load 2 samples, then pulse i_rst for 1 cycle, then load 9,9,9,9 -> outputs 18, 0, 18, 0; no stale data; o_frame_cnt=1.
REQ-035 Run 256 frames -> o_frame_cnt reads 0 after the 256th o_m_last transfer; 257th frame gives 1.

Source files
------------

// File: rtl/dft4_sequencer.sv
// 4-point DFT sequencer: collects four serial samples into operand registers,
// captures the external DFT network results in one cycle, then streams the
// four results out serially with a last marker and a frame counter.
module dft4_sequencer #(
    parameter int WORD_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [WORD_SZ-1:0] i_s_data,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    output logic [WORD_SZ-1:0] o_net_A,
    output logic [WORD_SZ-1:0] o_net_B,
    output logic [WORD_SZ-1:0] o_net_C,
    output logic [WORD_SZ-1:0] o_net_D,
    input  logic [WORD_SZ-1:0] i_net_A,
    input  logic [WORD_SZ-1:0] i_net_B,
    input  logic [WORD_SZ-1:0] i_net_C,
    input  logic [WORD_SZ-1:0] i_net_D,
    output logic [WORD_SZ-1:0] o_m_data,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic               o_m_last,
    output logic [7:0]         o_frame_cnt
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         load_idx_q, load_idx_d;
    logic [1:0]         out_idx_q, out_idx_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [WORD_SZ-1:0] op_q  [4];
    logic [WORD_SZ-1:0] res_q [4];
    logic [WORD_SZ-1:0] net_in [4];
    logic               s_xfer;
    logic               m_xfer;

    assign net_in[0] = i_net_A;
    assign net_in[1] = i_net_B;
    assign net_in[2] = i_net_C;
    assign net_in[3] = i_net_D;

    // Handshake outputs; ready is masked during reset so nothing is accepted
    // while the block is being cleared.
    always_comb begin
        o_s_ready = (state_q == LOAD) && !i_rst;
        o_m_valid = (state_q == UNLOAD);
        o_m_data  = res_q[out_idx_q];
        o_m_last  = (state_q == UNLOAD) && (out_idx_q == 2'd3);
        s_xfer    = o_s_ready && i_s_valid;
        m_xfer    = o_m_valid && i_m_ready;
    end

    assign o_net_A     = op_q[0];
    assign o_net_B     = op_q[1];
    assign o_net_C     = op_q[2];
    assign o_net_D     = op_q[3];
    assign o_frame_cnt = frame_cnt_q;

    // Next-state logic: load four samples, one compute cycle, unload four results.
    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        out_idx_d   = out_idx_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            LOAD: begin
                if (s_xfer) begin
                    load_idx_d = load_idx_q + 2'd1;
                    if (load_idx_q == 2'd3) begin
                        load_idx_d = 2'd0;
                        state_d    = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                state_d = UNLOAD;
            end
            UNLOAD: begin
                if (m_xfer) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        out_idx_d   = 2'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = LOAD;
                    end
                end
            end
            default: begin
                state_d    = LOAD;
                load_idx_d = 2'd0;
                out_idx_d  = 2'd0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= LOAD;
            load_idx_q  <= 2'd0;
            out_idx_q   <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            out_idx_q   <= out_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            // Operand slot: written only by an accepted sample aimed at this slot,
            // so it keeps the previous frame's value until reloaded.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    op_q[gi] <= '0;
                end else if (s_xfer && (load_idx_q == 2'(gi))) begin
                    op_q[gi] <= i_s_data;
                end
            end

            // Result slot: samples the network only during the compute cycle.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    res_q[gi] <= '0;
                end else if (state_q == COMPUTE) begin
                    res_q[gi] <= net_in[gi];
                end
            end
        end
    endgenerate

endmodule
